// File: rtl/prog_mem_loader_pkg.sv
// Shared types and default parameters for the program memory loader.
package prog_mem_loader_pkg;

  localparam int         DEFAULT_ADDR_W    = 15;
  localparam int         DEFAULT_DEPTH     = 23040;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/prog_mem_loader.sv
// Program memory loader: parses a framed byte stream, assembles little-endian
// words, writes them from word 0 into the program RAM and holds the CPU in
// reset while an image is being loaded or after a rejected image.
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int         ADDR_W    = DEFAULT_ADDR_W,
  parameter int         DEPTH     = DEFAULT_DEPTH,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              cpu_reset_req,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W-1:0] words_written
);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  lane;
  logic [7:0]  csum;
  logic        take;
  logic [15:0] frame_len;

  // A byte moves whenever the source offers one and we are not in a write cycle.
  assign take      = in_valid & in_ready;
  assign frame_len = {in_data, len_lo};

  // Frame parser, word assembler and RAM write sequencer; every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      len_lo         <= 8'd0;
      len            <= 16'd0;
      lane           <= 2'd0;
      csum           <= 8'd0;
      in_ready       <= 1'b1;
      mem_address    <= '0;
      mem_byteenable <= 4'hF;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'd0;
      cpu_reset_req  <= 1'b0;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      words_written  <= '0;
    end else begin
      mem_byteenable <= 4'hF;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (take && in_data == SYNC_BYTE) begin
            state         <= ST_LEN_LO;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            words_written <= '0;
            csum          <= 8'd0;
            mem_address   <= '0;
            cpu_reset_req <= 1'b1;
          end
        end
        ST_LEN_LO: begin
          if (take) begin
            len_lo <= in_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (take) begin
            len <= frame_len;
            if (frame_len == 16'd0 || 32'(frame_len) > DEPTH) begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end else begin
              state <= ST_DATA;
              lane  <= 2'd0;
            end
          end
        end
        ST_DATA: begin
          if (take) begin
            mem_writedata[{lane, 3'b000} +: 8] <= in_data;
            csum <= csum + in_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              state          <= ST_WRITE;
              mem_write      <= 1'b1;
              mem_chipselect <= 1'b1;
              mem_address    <= words_written;
              in_ready       <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          mem_write      <= 1'b0;
          mem_chipselect <= 1'b0;
          in_ready       <= 1'b1;
          words_written  <= words_written + ADDR_W'(1);
          if (32'(words_written) == 32'(len) - 32'd1) begin
            state <= ST_CSUM;
          end else begin
            state <= ST_DATA;
          end
        end
        ST_CSUM: begin
          if (take) begin
            if (in_data == csum) begin
              state         <= ST_DONE;
              load_done     <= 1'b1;
              cpu_reset_req <= 1'b0;
            end else begin
              state      <= ST_ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
